// File: rtl/intl_dispatch.sv
// ----------------------------------------------------------------------------
// intl_dispatch
//
// Dispatches instructions from the decoder to the integer-logic unit and writes
// the results back to the register file.
//   - A 2-entry FIFO buffers accepted {fct, ra, rb, rc, const} tuples.
//   - The FIFO head reads the register file combinationally and issues into
//     registered unit drive (exu_*) unless a RAW hazard or a same-function
//     bubble holds it back.
//   - Three pipeline trackers (I, X, W) carry each issued entry's destination
//     until its write-back. They also supply the hazard check.
//
// Ports
//   clk, rst_n                  clock; asynchronous active-low reset
//   in_valid / in_ready         decode handshake
//   in_fct, in_ra, in_rb,       instruction fields; in_const[8] = literal
//   in_rc, in_const             valid, in_const[7:0] = literal
//   rf_raddr_a/b, rf_rdata_a/b  combinational register-file read port
//   exu_fct, exu_op1/2,         registered drive to the logic unit
//   exu_const
//   exu_resdata, exu_cond       unit result / cmov condition (X stage)
//   rf_we, rf_waddr, rf_wdata   registered register-file write port
//   busy                        any buffered or in-flight instruction
// ----------------------------------------------------------------------------
module intl_dispatch #(
    parameter logic [6:0] BUBBLE_FCT = 7'h7F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_fct,
    input  logic [4:0]  in_ra,
    input  logic [4:0]  in_rb,
    input  logic [4:0]  in_rc,
    input  logic [8:0]  in_const,
    output logic [4:0]  rf_raddr_a,
    output logic [4:0]  rf_raddr_b,
    input  logic [63:0] rf_rdata_a,
    input  logic [63:0] rf_rdata_b,
    output logic [6:0]  exu_fct,
    output logic [63:0] exu_op1,
    output logic [63:0] exu_op2,
    output logic [8:0]  exu_const,
    input  logic [63:0] exu_resdata,
    input  logic        exu_cond,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic        busy
);

    localparam logic [4:0] R31 = 5'd31;

    typedef struct packed {
        logic [6:0] fct;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] rc;
        logic [8:0] cst;
    } instr_t;

    // FIFO storage and pointers
    instr_t     r_fifo [2];
    logic       r_rd_ptr;
    logic       r_wr_ptr;
    logic [1:0] r_count;

    // Unit drive registers
    logic [6:0]  r_exu_fct;
    logic [63:0] r_exu_op1;
    logic [63:0] r_exu_op2;
    logic [8:0]  r_exu_const;

    // Pipeline trackers; the W stage destination lives in r_rf_waddr
    logic        r_i_valid;
    logic [4:0]  r_i_rc;
    logic        r_x_valid;
    logic [4:0]  r_x_rc;
    logic        r_w_valid;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [63:0] r_rf_wdata;

    logic   w_empty;
    logic   w_full;
    logic   w_push;
    instr_t w_head;
    logic   w_hazard;
    logic   w_bubble;
    logic   w_issue;

    // True when a non-R31 source matches the destination of a valid stage.
    function automatic logic src_pending(
        input logic [4:0] src,
        input logic       i_v, input logic [4:0] i_rc,
        input logic       x_v, input logic [4:0] x_rc,
        input logic       w_v, input logic [4:0] w_rc
    );
        return (src != R31) &&
               ((i_v && (i_rc == src)) || (x_v && (x_rc == src)) ||
                (w_v && (w_rc == src)));
    endfunction

    assign w_empty = (r_count == 2'd0);
    assign w_full  = (r_count == 2'd2);
    // Gated by rst_n so the port reads low for the whole reset, and high as
    // soon as reset is released.
    assign in_ready = rst_n & ~w_full;
    assign w_push   = in_valid & in_ready;

    // NOTE: every signal assigned in always_comb gets a default first so that
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_head   = r_fifo[r_rd_ptr];
        w_hazard = 1'b0;
        w_bubble = 1'b0;
        w_issue  = 1'b0;
        if (!w_empty) begin
            w_hazard = src_pending(w_head.ra, r_i_valid, r_i_rc, r_x_valid,
                                   r_x_rc, r_w_valid, r_rf_waddr) |
                       src_pending(w_head.rb, r_i_valid, r_i_rc, r_x_valid,
                                   r_x_rc, r_w_valid, r_rf_waddr);
            // The unit only re-evaluates on a function-code change, so a
            // repeated code needs a bubble in between. The bubble code itself
            // always decodes to a constant result and never needs one.
            w_bubble = (w_head.fct == r_exu_fct) && (w_head.fct != BUBBLE_FCT);
            w_issue  = !w_hazard && !w_bubble;
        end
    end

    assign rf_raddr_a = w_empty ? 5'd0 : w_head.ra;
    assign rf_raddr_b = w_empty ? 5'd0 : w_head.rb;

    // NOTE: the FIFO payload has no reset; the count qualifies every read, so
    // clearing the storage would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{fct: in_fct, ra: in_ra, rb: in_rb,
                                  rc: in_rc, cst: in_const};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push)  r_wr_ptr <= ~r_wr_ptr;
            if (w_issue) r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Unit drive: the operands and the literal hold on non-issue edges, and
    // the function code drops to the bubble code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exu_fct   <= BUBBLE_FCT;
            r_exu_op1   <= '0;
            r_exu_op2   <= '0;
            r_exu_const <= '0;
        end else if (w_issue) begin
            r_exu_fct   <= w_head.fct;
            r_exu_op1   <= (w_head.ra == R31) ? 64'd0 : rf_rdata_a;
            r_exu_op2   <= (w_head.rb == R31) ? 64'd0 : rf_rdata_b;
            r_exu_const <= w_head.cst;
        end else begin
            r_exu_fct   <= BUBBLE_FCT;
        end
    end

    // I -> X -> W tracking and write-back capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_valid  <= 1'b0;
            r_i_rc     <= '0;
            r_x_valid  <= 1'b0;
            r_x_rc     <= '0;
            r_w_valid  <= 1'b0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_i_valid <= w_issue;
            if (w_issue) r_i_rc <= w_head.rc;
            r_x_valid <= r_i_valid;
            r_x_rc    <= r_i_rc;
            r_w_valid <= r_x_valid;
            // A false cmov still occupies W; it just does not write.
            r_rf_we   <= r_x_valid & exu_cond & (r_x_rc != R31);
            if (r_x_valid) begin
                r_rf_waddr <= r_x_rc;
                r_rf_wdata <= exu_resdata;
            end
        end
    end

    assign exu_fct   = r_exu_fct;
    assign exu_op1   = r_exu_op1;
    assign exu_op2   = r_exu_op2;
    assign exu_const = r_exu_const;
    assign rf_we     = r_rf_we;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;
    assign busy      = ~w_empty | r_i_valid | r_x_valid | r_w_valid;

endmodule
